// File: rtl/hazard_scoreboard.sv
// Decode-stage RAW hazard scoreboard: shift register of in-flight destinations mirroring the pipeline.
// stall_out is combinational (0-cycle); enable_in low freezes all state, flush_in clears the youngest slots.
module hazard_scoreboard #(
  parameter int DEPTH       = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter bit FWD_EN      = 1'b0,
  parameter int LOAD_SHADOW = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_in,
  input  logic             flush_in,
  input  logic             id_valid_in,
  input  logic [3:0]       id_rd_a_in,
  input  logic [3:0]       id_rd_b_in,
  input  logic [3:0]       id_sr_rd_in,
  input  logic             id_dst_en_in,
  input  logic             id_dst_sr_in,
  input  logic [3:0]       id_dst_in,
  input  logic             id_dst_load_in,
  output logic             stall_out,
  output logic [15:0]      pending_gp_out,
  output logic [15:0]      pending_sr_out,
  output logic [CNT_W-1:0] stall_cnt_out
);

  typedef struct packed {
    logic       vld;
    logic       sr;
    logic       load;
    logic [3:0] addr;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;
  logic             issue;

  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      logic m;
      m = 1'b0;
      if (ent_q[k].vld && ent_q[k].addr != 4'd0) begin
        if (!ent_q[k].sr)
          m = (id_rd_a_in != 4'd0 && id_rd_a_in == ent_q[k].addr) ||
              (id_rd_b_in != 4'd0 && id_rd_b_in == ent_q[k].addr);
        else
          m = (id_sr_rd_in != 4'd0 && id_sr_rd_in == ent_q[k].addr);
      end
      // With forwarding only a load still inside its shadow cannot be bypassed.
      if (!FWD_EN)
        hit = hit | m;
      else if (ent_q[k].load && k < LOAD_SHADOW)
        hit = hit | m;
    end
  end

  assign stall_out = rst & id_valid_in & ~flush_in & hit;
  assign issue     = enable_in & id_valid_in & id_dst_en_in & ~stall_out & ~flush_in &
                     (id_dst_in != 4'd0);

  always_comb begin
    for (int k = 0; k < DEPTH; k++) ent_d[k] = ent_q[k];
    if (enable_in) begin
      for (int k = 1; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
      ent_d[0] = issue ? {1'b1, id_dst_sr_in, id_dst_load_in, id_dst_in} : '0;
    end
    if (flush_in) begin
      for (int k = 0; k < FLUSH_DEPTH; k++) ent_d[k].vld = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (enable_in && stall_out && cnt_q != {CNT_W{1'b1}})
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) ent_q[k] <= ent_d[k];
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pending_gp_out = 16'h0000;
    pending_sr_out = 16'h0000;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_q[k].vld) begin
        if (ent_q[k].sr) pending_sr_out[ent_q[k].addr] = 1'b1;
        else             pending_gp_out[ent_q[k].addr] = 1'b1;
      end
    end
    pending_gp_out[0] = 1'b0;
    pending_sr_out[0] = 1'b0;
  end

  assign stall_cnt_out = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: dut0 uses defaults (no forwarding), dut1 has forwarding and a 2-bit stall counter.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst, enable_in, flush_in, id_valid_in;
  logic [3:0]  id_rd_a_in, id_rd_b_in, id_sr_rd_in, id_dst_in;
  logic        id_dst_en_in, id_dst_sr_in, id_dst_load_in;
  logic        stall0, stall1;
  logic [15:0] pgp0, psr0, pgp1, psr1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(3), .FLUSH_DEPTH(2), .FWD_EN(1'b0), .LOAD_SHADOW(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .enable_in(enable_in), .flush_in(flush_in),
    .id_valid_in(id_valid_in), .id_rd_a_in(id_rd_a_in), .id_rd_b_in(id_rd_b_in),
    .id_sr_rd_in(id_sr_rd_in), .id_dst_en_in(id_dst_en_in), .id_dst_sr_in(id_dst_sr_in),
    .id_dst_in(id_dst_in), .id_dst_load_in(id_dst_load_in), .stall_out(stall0),
    .pending_gp_out(pgp0), .pending_sr_out(psr0), .stall_cnt_out(cnt0));

  hazard_scoreboard #(.DEPTH(3), .FLUSH_DEPTH(2), .FWD_EN(1'b1), .LOAD_SHADOW(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .enable_in(enable_in), .flush_in(flush_in),
    .id_valid_in(id_valid_in), .id_rd_a_in(id_rd_a_in), .id_rd_b_in(id_rd_b_in),
    .id_sr_rd_in(id_sr_rd_in), .id_dst_en_in(id_dst_en_in), .id_dst_sr_in(id_dst_sr_in),
    .id_dst_in(id_dst_in), .id_dst_load_in(id_dst_load_in), .stall_out(stall1),
    .pending_gp_out(pgp1), .pending_sr_out(psr1), .stall_cnt_out(cnt1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid_in = 1'b0; id_rd_a_in = 4'd0; id_rd_b_in = 4'd0; id_sr_rd_in = 4'd0;
    id_dst_en_in = 1'b0; id_dst_sr_in = 1'b0; id_dst_in = 4'd0; id_dst_load_in = 1'b0;
  endtask

  task automatic wr(input logic [3:0] dst, input logic sr, input logic ld);
    idle();
    id_valid_in = 1'b1; id_dst_en_in = 1'b1; id_dst_in = dst; id_dst_sr_in = sr; id_dst_load_in = ld;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b, input logic [3:0] s);
    idle();
    id_valid_in = 1'b1; id_rd_a_in = a; id_rd_b_in = b; id_sr_rd_in = s;
  endtask

  initial begin
    rst = 1'b0; enable_in = 1'b1; flush_in = 1'b0;
    idle();
    step();
    chk("reset_stall", stall0, 0);
    chk("reset_pgp", pgp0, 0);
    chk("reset_cnt", cnt0, 0);
    rst = 1'b1;

    // Reset asserted in the middle of a stall.
    wr(4'd1, 1'b0, 1'b0); step();
    wr(4'd2, 1'b0, 1'b0); step();
    wr(4'd3, 1'b0, 1'b0); step();
    idle(); #1;
    chk("fill_pgp", pgp0, 16'h000E);
    rd(4'd1, 4'd0, 4'd0); #1;
    chk("fill_stall_r1", stall0, 1);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_mid_stall", stall0, 0);
    chk("rst_mid_pgp", pgp0, 0);
    step(); rst = 1'b1; #1;
    chk("post_rst_stall", stall0, 0);
    chk("post_rst_pgp", pgp0, 0);
    chk("post_rst_cnt", cnt0, 0);
    idle(); step();

    // RAW on GP: exactly DEPTH stalled cycles.
    wr(4'd3, 1'b0, 1'b0); step();
    rd(4'd3, 4'd0, 4'd0); #1;
    chk("raw_pgp", pgp0, 16'h0008);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("raw_stall%0d", i), stall0, 1);
      step();
    end
    chk("raw_release", stall0, 0);
    chk("raw_cnt", cnt0, 3);
    chk("raw_fwd_nostall_cnt", cnt1, 0);
    idle(); step();

    // SR and GP files are separate; r0 is never a dependency.
    wr(4'd2, 1'b1, 1'b0); step();
    rd(4'd2, 4'd0, 4'd0); #1;
    chk("gp_vs_sr2", stall0, 0);
    rd(4'd0, 4'd0, 4'd2); #1;
    chk("sr_vs_sr2", stall0, 1);
    chk("sr_psr", psr0, 16'h0004);
    chk("sr_pgp", pgp0, 16'h0000);
    idle(); #1;
    step(); step(); step();
    wr(4'd0, 1'b0, 1'b0); step();
    rd(4'd0, 4'd0, 4'd0); #1;
    chk("r0_stall", stall0, 0);
    chk("r0_pgp", pgp0, 0);
    chk("r0_psr", psr0, 0);
    chk("r0_cnt", cnt0, 3);
    idle(); step();

    // Flush overrides the stall and kills the young writer.
    wr(4'd5, 1'b0, 1'b0); step();
    rd(4'd5, 4'd0, 4'd0); #1;
    chk("flush_pre_stall", stall0, 1);
    flush_in = 1'b1; #1;
    chk("flush_stall", stall0, 0);
    step(); flush_in = 1'b0; #1;
    chk("flush_pgp", pgp0, 0);
    chk("flush_after_stall", stall0, 0);
    chk("flush_cnt", cnt0, 3);
    idle(); step();

    // Freeze during a stall.
    wr(4'd3, 1'b0, 1'b0); step();
    rd(4'd3, 4'd0, 4'd0); #1;
    chk("frz_stall_a", stall0, 1);
    step();
    enable_in = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("frz_stall%0d", i), stall0, 1);
      chk($sformatf("frz_cnt%0d", i), cnt0, 4);
      chk($sformatf("frz_pgp%0d", i), pgp0, 16'h0008);
      step();
    end
    enable_in = 1'b1; #1;
    chk("frz_resume_stall", stall0, 1);
    step();
    chk("frz_resume_cnt", cnt0, 5);
    chk("frz_resume_stall2", stall0, 1);
    step();
    chk("frz_release", stall0, 0);
    chk("frz_final_cnt", cnt0, 6);
    idle(); step();

    // Forwarding: only a load at entry 0 stalls, counter saturates at 3.
    @(negedge clk); rst = 1'b0; #1; rst = 1'b1;
    chk("fwd_rst_cnt", cnt1, 0);
    step();
    wr(4'd4, 1'b0, 1'b0); step();
    rd(4'd4, 4'd0, 4'd0); #1;
    chk("fwd_alu_nostall", stall1, 0);
    idle(); step(); step(); step();
    wr(4'd4, 1'b0, 1'b1); step();
    rd(4'd4, 4'd0, 4'd0); #1;
    chk("fwd_load_stall", stall1, 1);
    step();
    chk("fwd_load_release", stall1, 0);
    chk("fwd_cnt1", cnt1, 1);
    for (int i = 2; i <= 5; i++) begin
      wr(4'd4, 1'b0, 1'b1); step();
      rd(4'd4, 4'd0, 4'd0); #1;
      chk($sformatf("sat_stall%0d", i), stall1, 1);
      step();
      chk($sformatf("sat_cnt%0d", i), cnt1, (i > 3) ? 3 : i);
    end
    idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Pipeline hazard controller that generates the decode-stage stall.
- Tracks destination registers (GP and SR files) of instructions issued out of decode and still in flight, in a shift register that mirrors the pipeline.
- Stalls the instruction in decode while any register it reads has a pending write.
- Also handles flush invalidation and keeps a saturating stall-cycle counter.

Parameters:
- DEPTH, 3: in-flight positions between decode output and register-file write (entry 0 = just issued).
- FLUSH_DEPTH, 2: number of youngest positions invalidated by flush_in; must be ≤ DEPTH.
- FWD_EN, 0: 1 = EX/MEM forwarding exists; only load entries at positions below LOAD_SHADOW cause a stall.
- LOAD_SHADOW, 1: load-use stall window, used only when FWD_EN=1; must be ≤ DEPTH.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- enable_in  in  1  pipeline advance; low freezes all state.
- flush_in  in  1  branch/redirect flush.
- id_valid_in  in  1  decode holds a real instruction (not a bubble or NOP).
- id_rd_a_in  in  4  first GP read address; 0 = no dependency.
- id_rd_b_in  in  4  second GP read address; 0 = no dependency.
- id_sr_rd_in  in  4  SR read address; 0 = no dependency.
- id_dst_en_in  in  1  instruction writes a register.
- id_dst_sr_in  in  1  destination is in the SR file (0 = GP).
- id_dst_in  in  4  destination address.
- id_dst_load_in  in  1  destination is produced by a load.
- stall_out  out  1  combinational stall to decode.
- pending_gp_out  out  16  bitmap of GP registers with an in-flight write.
- pending_sr_out  out  16  bitmap of SR registers with an in-flight write.
- stall_cnt_out  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- State: entry[0..DEPTH-1], each holding {valid, sr, load, addr[3:0]}.
- Reset (rst=0, asynchronous, any time, including mid-stall):
  - all entries invalid, stall_cnt_out=0.
  - stall_out forced to 0 while rst=0.
  - pending bitmaps therefore read 0.
- Match for entry k (evaluated only when entry k is valid):
  - GP: sr=0, addr≠0, and addr equals a nonzero id_rd_a_in or id_rd_b_in.
  - SR: sr=1, addr≠0, and addr equals a nonzero id_sr_rd_in.
  - Address 0 never matches, in either file.
- Stall qualification:
  - FWD_EN=0: any matching entry counts.
  - FWD_EN=1: only matching entries with load=1 and k < LOAD_SHADOW count.
- stall_out = rst & id_valid_in & !flush_in & (any qualifying match). Purely combinational, same cycle as decode.
- Issue qualification: issue = enable_in & id_valid_in & id_dst_en_in & !stall_out & !flush_in & (id_dst_in≠0).
- Clock edge with enable_in=1 and flush_in=0:
  - entry[k] <= entry[k-1] for k ≥ 1.
  - entry[0] <= issue ? {1, id_dst_sr_in, id_dst_load_in, id_dst_in} : invalid.
  - A stall therefore inserts a bubble, consistent with the decode-stage NOP insertion.
  - entry[DEPTH-1] retires (register-file write complete) on the following shift.
- Clock edge with enable_in=1 and flush_in=1:
  - shift as above, but entry[0] and every shifted-in position k < FLUSH_DEPTH become invalid.
- Clock edge with enable_in=0:
  - no shift, no issue.
  - if flush_in=1, entries k < FLUSH_DEPTH are cleared in place.
  - stall_out is still computed.
- stall_cnt_out:
  - +1 on each edge with enable_in & stall_out.
  - holds at all-ones (no wrap).
  - cleared only by reset.
- Pending bitmaps:
  - bit r = OR over valid entries of the matching file with addr=r.
  - bit 0 always 0.
  - functions of registered state only (no input path).
- Latency: a writer issued at edge N blocks a dependent reader through edge N+DEPTH-1; the reader proceeds in the cycle after edge N+DEPTH (FWD_EN=0).
- Simultaneous events:
  - flush overrides stall and issue.
  - a reader that depends on the instruction issuing this cycle is evaluated next cycle against entry 0.

Test Plan:
- Reset: fill entries (writers to r1, r2, r3), then drive rst=0 mid-stall → stall_out=0 immediately; pending_gp_out=0 and stall_cnt_out=0 after release; no stall on the next reader of r1.
- RAW on GP (DEPTH=3, FWD_EN=0): issue writer r3, then reader id_rd_a_in=3 → stall_out=1 for exactly 3 enabled cycles then 0; stall_cnt_out=3; pending_gp_out=16'h0008 during the stall.
- File separation and r0: writer SR2, then GP reader r2 → no stall; SR reader sr2 → stall. Writer dst=0, then reader of r0 → no stall and no entry created.
- Flush (FLUSH_DEPTH=2): issue writer r5, reader r5 stalls; assert flush_in in stall cycle 1 → stall_out=0 that cycle; entry invalidated; pending_gp_out=0 next cycle.
- Freeze: during an r3 stall, hold enable_in=0 for 5 cycles → stall_out stays 1, stall_cnt_out unchanged, pending_gp_out unchanged; stall resumes counting after enable returns.
- Forwarding (FWD_EN=1, LOAD_SHADOW=1): ALU writer r4, then reader r4 → no stall. Load writer r4, then reader r4 → stall exactly 1 cycle. CNT_W=2: stall for 5 cycles → counter saturates at 3.
